// File: rtl/branch_redirect_ctrl.sv
// Purpose: arbitrates branch/jump redirects, issues the new fetch PC, flushes
//          younger stages and stalls fetch until the fetch unit restarts.
// Latency: request sampled in IDLE at edge T -> ack/redirect_valid/flush in T+1.
// Backpressure: requests are held by the requester; none are accepted while
//          FLUSH or WAIT_FETCH, so fetch_stall is the effective "not ready".
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   br_req/br_pc/br_imm        execute-stage branch redirect (held until br_ack)
//   jmp_req/jmp_target         decode-stage jump redirect (held until jmp_ack)
//   fetch_ready                fetch has restarted at redirect_pc
//   br_ack/jmp_ack             one-cycle acceptance pulses
//   redirect_valid/redirect_pc new fetch PC pulse / held value
//   is_jump                    last accepted redirect was a jump
//   flush, fetch_stall         pipeline squash / fetch hold
//   redirect_count             saturating accepted-redirect counter
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_req,
  input  logic [32:0] br_pc,
  input  logic [15:0] br_imm,
  input  logic        jmp_req,
  input  logic [32:0] jmp_target,
  input  logic        fetch_ready,
  output logic        br_ack,
  output logic        jmp_ack,
  output logic        redirect_valid,
  output logic [32:0] redirect_pc,
  output logic        is_jump,
  output logic        flush,
  output logic        fetch_stall,
  output logic [7:0]  redirect_count
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_FLUSH      = 2'd1;
  localparam logic [1:0] ST_WAIT_FETCH = 2'd2;

  // Counter is loaded with N-1 so FLUSH lasts exactly N cycles including entry.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        br_ack_q, br_ack_d;
  logic        jmp_ack_q, jmp_ack_d;
  logic        rv_q, rv_d;
  logic [32:0] pc_q, pc_d;
  logic        is_jump_q, is_jump_d;
  logic [7:0]  count_q, count_d;
  logic        jmp_drop_q, jmp_drop_d;
  logic [32:0] br_target;
  logic        accept;

  // Signed word offset: sign-extend to 31 bits then shift by 2 -> 33 bits.
  assign br_target = br_pc + 33'd4 + {{15{br_imm[15]}}, br_imm, 2'b00};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    br_ack_d   = 1'b0;
    jmp_ack_d  = 1'b0;
    rv_d       = 1'b0;
    pc_d       = pc_q;
    is_jump_d  = is_jump_q;
    count_d    = count_q;
    accept     = 1'b0;

    // A jump seen during flush is stale for good; it stays blocked until the
    // requester lowers it, even if it lingers into the next IDLE.
    if (!jmp_req)
      jmp_drop_d = 1'b0;
    else if (state_q == ST_FLUSH)
      jmp_drop_d = 1'b1;
    else
      jmp_drop_d = jmp_drop_q;

    case (state_q)
      ST_IDLE: begin
        if (br_req) begin
          accept    = 1'b1;
          br_ack_d  = 1'b1;
          pc_d      = br_target;
          is_jump_d = 1'b0;
        end else if (jmp_req && !jmp_drop_q) begin
          accept    = 1'b1;
          jmp_ack_d = 1'b1;
          pc_d      = jmp_target;
          is_jump_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0)
          state_d = ST_WAIT_FETCH;
        else
          cnt_d = cnt_q - 4'd1;
      end
      ST_WAIT_FETCH: begin
        if (fetch_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_FLUSH;
      cnt_d   = FLUSH_LOAD;
      rv_d    = 1'b1;
      if (count_q != 8'hFF)
        count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      br_ack_q   <= 1'b0;
      jmp_ack_q  <= 1'b0;
      rv_q       <= 1'b0;
      pc_q       <= 33'd0;
      is_jump_q  <= 1'b0;
      count_q    <= 8'd0;
      jmp_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      br_ack_q   <= br_ack_d;
      jmp_ack_q  <= jmp_ack_d;
      rv_q       <= rv_d;
      pc_q       <= pc_d;
      is_jump_q  <= is_jump_d;
      count_q    <= count_d;
      jmp_drop_q <= jmp_drop_d;
    end
  end

  assign br_ack         = br_ack_q;
  assign jmp_ack        = jmp_ack_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;
  assign is_jump        = is_jump_q;
  assign flush          = (state_q == ST_FLUSH);
  assign fetch_stall    = (state_q != ST_IDLE);
  assign redirect_count = count_q;

endmodule
